// File: rtl/stack_access_seq.sv
// -----------------------------------------------------------------------------
// stack_access_seq
//
// Sequencer that sits directly in front of the stack pointer register.
// It drives the pointer controls (sbin/wa/dec/adloa), forms stack addresses
// {STACK_PAGE, SP} from the pointer's ADL output, and moves 1..3 bytes
// between a payload register and a synchronous stack RAM.
//
// A push writes the high byte first and decrements SP after each write.
// A pull pre-increments SP, reads, and captures the byte one cycle later.
// A single-cycle done pulse closes every accepted request, including the
// zero-byte (null) request.
//
// Optional feature (compile-time macro STACK_WRAP_FLAG_EN):
//   Adds output 'wrap', a sticky flag raised whenever the pointer wraps
//   around the page (push at SP=00 or pre-increment at SP=FF). The flag
//   is cleared when the next request is accepted.
//
// Reset is asynchronous and active-low (clr_n). All strobes are decoded
// combinationally from the state register, so they fall as soon as reset
// is asserted.
// -----------------------------------------------------------------------------
module stack_access_seq #(
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        req,
    input  logic        op,
    input  logic [1:0]  nbytes,
    input  logic [23:0] push_data,
    output logic [23:0] pull_data,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  sp_adl,
    output logic        sp_adloa,
    output logic        sp_dec,
    output logic        sp_wa,
    output logic [7:0]  sp_sbout,
    output logic [15:0] addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata
`ifdef STACK_WRAP_FLAG_EN
    ,
    output logic        wrap
`endif
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH     = 3'd1,
        ST_PULL_INC = 3'd2,
        ST_PULL_RD  = 3'd3,
        ST_PULL_CAP = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t      state_q, state_d;

    // Request context latched at acceptance
    logic        op_q,        op_d;
    logic [1:0]  nbytes_q,    nbytes_d;
    logic [23:0] push_data_q, push_data_d;

    // Byte counter: number of bytes already transferred in this request
    logic [1:0]  cnt_q,       cnt_d;

    // Per-byte pull result registers
    logic [7:0]  pull_byte_q [3];

    // Helper decodes
    logic        accept;
    logic        last_byte;
    logic        pull_clear;
    logic        pull_capture;
    logic [1:0]  push_idx;
    logic [7:0]  push_byte;

    // A request is only looked at while idle; busy masks it otherwise.
    assign accept       = (state_q == ST_IDLE) && req;

    // True on the cycle that handles the final byte of the transfer.
    assign last_byte    = (cnt_q == (nbytes_q - 2'd1));

    // Starting a non-empty pull wipes the previous result so stale bytes
    // never survive in lanes beyond the new byte count.
    assign pull_clear   = accept && op && (nbytes != 2'd0);

    // Read data from PULL_RD is valid on mem_rdata during PULL_CAP.
    assign pull_capture = (state_q == ST_PULL_CAP);

    // High byte goes out first: lane (nbytes-1-cnt).
    assign push_idx     = nbytes_q - 2'd1 - cnt_q;

    // Select the push payload lane for the current byte.
    always_comb begin
        push_byte = 8'h00;
        case (push_idx)
            2'd0:    push_byte = push_data_q[7:0];
            2'd1:    push_byte = push_data_q[15:8];
            2'd2:    push_byte = push_data_q[23:16];
            default: push_byte = 8'h00;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    // State register with asynchronous abort on reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    // Sequence push bytes one per cycle and pulls as INC/RD/CAP triplets.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (nbytes == 2'd0) begin
                        state_d = ST_DONE;
                    end else if (!op) begin
                        state_d = ST_PUSH;
                    end else begin
                        state_d = ST_PULL_INC;
                    end
                end
            end
            ST_PUSH: begin
                if (last_byte) begin
                    state_d = ST_DONE;
                end
            end
            ST_PULL_INC: begin
                state_d = ST_PULL_RD;
            end
            ST_PULL_RD: begin
                state_d = ST_PULL_CAP;
            end
            ST_PULL_CAP: begin
                if (last_byte) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PULL_INC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: output decode
    // -------------------------------------------------------------------------
    // Strobes, address and SP controls are pure functions of the state so
    // that everything outside the named states is forced to zero.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        sp_adloa  = 1'b0;
        sp_dec    = 1'b0;
        sp_wa     = 1'b0;
        sp_sbout  = 8'h00;
        addr      = 16'h0000;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        mem_rd    = 1'b0;
        case (state_q)
            ST_PUSH: begin
                // Latched direction guards the strobe against a corrupt state.
                if (!op_q) begin
                    sp_adloa  = 1'b1;
                    mem_we    = 1'b1;
                    sp_dec    = 1'b1;
                    addr      = {STACK_PAGE, sp_adl};
                    mem_wdata = push_byte;
                end
            end
            ST_PULL_INC: begin
                if (op_q) begin
                    sp_wa    = 1'b1;
                    sp_sbout = sp_adl + 8'd1;   // FF wraps to 00 in the page
                end
            end
            ST_PULL_RD: begin
                if (op_q) begin
                    sp_adloa = 1'b1;
                    mem_rd   = 1'b1;
                    addr     = {STACK_PAGE, sp_adl};
                end
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request context and byte counter
    // -------------------------------------------------------------------------
    // Latch the request on acceptance and advance the counter per byte.
    always_comb begin
        op_d        = op_q;
        nbytes_d    = nbytes_q;
        push_data_d = push_data_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d        = op;
                    nbytes_d    = nbytes;
                    push_data_d = push_data;
                    cnt_d       = 2'd0;
                end
            end
            ST_PUSH,
            ST_PULL_CAP: begin
                cnt_d = cnt_q + 2'd1;
            end
            default: begin
            end
        endcase
    end

    // Context registers, cleared by reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            op_q        <= 1'b0;
            nbytes_q    <= 2'd0;
            push_data_q <= 24'h000000;
            cnt_q       <= 2'd0;
        end else begin
            op_q        <= op_d;
            nbytes_q    <= nbytes_d;
            push_data_q <= push_data_d;
            cnt_q       <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Pull result lanes
    // -------------------------------------------------------------------------
    // One byte lane per pulled byte; lane gi captures when cnt selects it.
    for (genvar gi = 0; gi < 3; gi++) begin : g_pull_lane
        // Clear on a new pull, capture read data for this lane, else hold.
        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                pull_byte_q[gi] <= 8'h00;
            end else if (pull_clear) begin
                pull_byte_q[gi] <= 8'h00;
            end else if (pull_capture && (cnt_q == 2'(gi))) begin
                pull_byte_q[gi] <= mem_rdata;
            end
        end

        assign pull_data[8*gi +: 8] = pull_byte_q[gi];
    end

`ifdef STACK_WRAP_FLAG_EN
    // -------------------------------------------------------------------------
    // Page wrap flag
    // -------------------------------------------------------------------------
    logic wrap_q;

    // Sticky wrap detect; a freshly accepted request starts with it clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wrap_q <= 1'b0;
        end else if (accept) begin
            wrap_q <= 1'b0;
        end else if (((state_q == ST_PUSH)     && (sp_adl == 8'h00)) ||
                     ((state_q == ST_PULL_INC) && (sp_adl == 8'hFF))) begin
            wrap_q <= 1'b1;
        end
    end

    assign wrap = wrap_q;
`endif

endmodule

// File: doc/stack_access_seq.md
Name: stack_access_seq

Overview:
- Sequencer directly upstream of the stack pointer register. It drives the pointer's `sbin`, `wa`, `dec` and `adloa` controls.
- It consumes the pointer's ADL output to form stack addresses `{STACK_PAGE, SP}`.
- It runs multi-byte push/pull transfers of 1-3 bytes against a synchronous stack RAM, as used by JSR/RTS/BRK/RTI/PHA/PLA.
- One request is accepted at a time; a one-cycle done pulse marks completion.

Parameters:
- STACK_PAGE, 8'h01, high address byte driven onto `addr[15:8]` during every stack access.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- clr_n  input  1  asynchronous, active-low reset
- req  input  1  start request; sampled only in IDLE
- op  input  1  0 = push, 1 = pull
- nbytes  input  2  byte count, 1..3; 0 = null transfer
- push_data  input  24  push payload; byte i = `push_data[8i+7:8i]`
- pull_data  output  24  pull result; byte i = i-th byte pulled
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- sp_adl  input  8  current SP value from the stack pointer's ADL output
- sp_adloa  output  1  enables the stack pointer's ADL output
- sp_dec  output  1  decrements SP on the next clock edge
- sp_wa  output  1  loads SP from `sp_sbout` on the next clock edge
- sp_sbout  output  8  value presented to the stack pointer's `sbin`
- addr  output  16  memory address
- mem_we  output  1  memory write strobe
- mem_wdata  output  8  memory write data
- mem_rd  output  1  memory read strobe; data valid on `mem_rdata` one cycle later
- mem_rdata  input  8  memory read data

Behaviour:
- Reset (clr_n = 0, async): state IDLE.
  - `pull_data` = 0; `busy`, `done`, `sp_adloa`, `sp_dec`, `sp_wa`, `mem_we`, `mem_rd` = 0.
  - `sp_sbout` = 0, `addr` = 0, `mem_wdata` = 0.
  - Reset mid-transfer aborts immediately; strobes drop asynchronously and no further SP or memory activity occurs.
- States: IDLE, PUSH, PULL_INC, PULL_RD, PULL_CAP, DONE.
  - Byte counter `cnt` (2 bits) and latched `op`, `nbytes`, `push_data` registers.
- IDLE:
  - `req` = 1 latches `op`, `nbytes` and `push_data`, and clears `cnt`.
  - nbytes = 0 goes to DONE; op = 0 goes to PUSH; op = 1 goes to PULL_INC.
  - On a pull with nbytes > 0, `pull_data` is cleared to 0.
- PUSH (one cycle per byte):
  - Asserts `sp_adloa`, `mem_we` and `sp_dec`.
  - `addr` = `{STACK_PAGE, sp_adl}`.
  - `mem_wdata` = byte (nbytes-1-cnt), so the high byte is pushed first.
  - cnt increments; when cnt = nbytes-1, go to DONE.
- PULL_INC: asserts `sp_wa` with `sp_sbout` = `sp_adl` + 1 (mod 256, FF wraps to 00), then goes to PULL_RD.
- PULL_RD: asserts `sp_adloa` and `mem_rd`, with `addr` = `{STACK_PAGE, sp_adl}`; goes to PULL_CAP.
- PULL_CAP:
  - Captures `mem_rdata` into `pull_data` byte cnt; cnt increments.
  - Goes to DONE when cnt = nbytes-1, otherwise back to PULL_INC.
- DONE: `done` = 1 for exactly one cycle; returns to IDLE.
- Latency:
  - Push: nbytes + 1 cycles from the req-sampling edge to the end of `done`.
  - Pull: 3·nbytes + 1 cycles.
  - Null transfer: 1 cycle.
- Push and pull wrap identically around the page: SP 00 decrements to FF, FF increments to 00, and the page byte never changes.
- Back-to-back requests:
  - `req` is ignored while `busy` = 1.
  - A req held high through DONE is accepted in the following IDLE cycle, so there is at least one idle cycle between transfers.
- Outside their named states, all strobes are 0, `addr` = 0 and `sp_sbout` = 0.
- `pull_data` holds its value until the next pull starts.

Optional Feature:
- Macro: STACK_WRAP_FLAG_EN.
- When defined, adds output `wrap` (1 bit, reset 0). `wrap` is a sticky flag that sets when:
  - a PUSH cycle occurs with `sp_adl` = 8'h00, or
  - a PULL_INC cycle occurs with `sp_adl` = 8'hFF.
- `wrap` clears when the next `req` is accepted.
- When not defined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Push, 2 bytes: SP = FF, req with op = 0, nbytes = 2, push_data = 24'h001234 → writes 01FF = 12 then 01FE = 34, two `sp_dec` pulses, done in cycle 3, SP = FD.
- Pull, 2 bytes: continuing from the push test, req with op = 1, nbytes = 2 → `sp_wa` loads FE and reads 01FE, then `sp_wa` loads FF and reads 01FF; pull_data = 24'h001234, done after 7 cycles, SP = FF.
- Push, 3 bytes with wrap: SP = 01, push_data = 24'hAABBCC → writes 0101 = AA, 0100 = BB, 01FF = CC; SP = FE; `wrap` = 1 when STACK_WRAP_FLAG_EN is defined.
- Null transfer: nbytes = 0 → done on the next cycle; no `mem_we`, `mem_rd`, `sp_dec` or `sp_wa` activity; SP unchanged.
- Request while busy: req pulsed mid-push → ignored; only the original transfer completes; `busy` falls after `done`.
- Reset mid-transfer: clr_n driven low during a 3-byte pull at PULL_RD → all outputs 0 immediately and state IDLE; after release, a new 1-byte pull completes normally.
